// File: rtl/serial_alu.sv
// Bit-serial LSB-first ALU: one result bit per clock, start/busy/done handshake.
// Define SERIAL_ALU_OVF_EN to build signed-overflow logic; otherwise ovf is tied to 0.
module serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       code_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             cy_q, cy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-2:0] sh_q, sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic             bit_r;
    logic             cy_n;
    logic             is_arith;
    logic             is_arith_in;
    logic             last;
    logic [WIDTH-1:0] res_full;

    assign is_arith    = op_q[2] & ~op_q[1];
    assign is_arith_in = code_op[2] & ~code_op[1];
    assign last        = (cnt_q == CW'(WIDTH - 1));
    assign res_full    = {bit_r, sh_q};

    // SUB runs a direct borrow chain; cy_q holds borrow-in, cy_n borrow-out.
    always_comb begin
        bit_r = 1'b0;
        cy_n  = 1'b0;
        unique case (op_q)
            OP_AND:  bit_r = a_q[0] & b_q[0];
            OP_OR:   bit_r = a_q[0] | b_q[0];
            OP_XOR:  bit_r = a_q[0] ^ b_q[0];
            OP_NOR:  bit_r = ~(a_q[0] | b_q[0]);
            OP_ADD: begin
                bit_r = a_q[0] ^ b_q[0] ^ cy_q;
                cy_n  = (a_q[0] & b_q[0]) | (a_q[0] & cy_q) | (b_q[0] & cy_q);
            end
            OP_SUB: begin
                bit_r = a_q[0] ^ b_q[0] ^ cy_q;
                cy_n  = (~a_q[0] & b_q[0]) | (~a_q[0] & cy_q) | (b_q[0] & cy_q);
            end
            OP_XNOR: bit_r = ~(a_q[0] ^ b_q[0]);
            OP_PASS: bit_r = a_q[0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        res_d   = res_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = code_op;
                    cy_d    = is_arith_in & cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d  = a_q >> 1;
                b_d  = b_q >> 1;
                cy_d = cy_n;
                sh_d = res_full[WIDTH-1:1];
                if (last) begin
                    state_d = IDLE;
                    res_d   = res_full;
                    cout_d  = is_arith & cy_n;
                    zero_d  = (res_full == '0);
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

`ifdef SERIAL_ALU_OVF_EN
    logic ovf_q, ovf_d;

    // Borrow-in xor borrow-out equals carry-in xor carry-out of the two's-complement form.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == RUN && last) begin
            ovf_d = is_arith & (cy_q ^ cy_n);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign result = res_q;
    assign cout   = cout_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_serial_alu.sv
// Directed vector bench for serial_alu (WIDTH=8), table sweep plus handshake corners.
module tb_serial_alu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic [2:0] code_op = '0;
    logic       busy, done, cout, zero, ovf;
    logic [7:0] result;

`ifdef SERIAL_ALU_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    serial_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .cin(cin), .code_op(code_op), .busy(busy), .done(done),
        .result(result), .cout(cout), .zero(zero), .ovf(ovf)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] res;
        logic       co;
        logic       z;
        logic       v;
    } vec_t;

    int total = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic run_op(input string nm, input logic [2:0] op, input logic [7:0] ia,
                          input logic [7:0] ib, input logic ic, input logic [7:0] er,
                          input logic ec, input logic ez, input logic ev);
        int n;
        @(negedge clk);
        a = ia; b = ib; cin = ic; code_op = op; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({nm, " busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk({nm, " latency"}, n, 32'd8);
        chk({nm, " res/cout/zero/ovf"}, {21'd0, result, cout, zero, ovf},
            {21'd0, er, ec, ez, ev & OVF_ON});
    endtask

    vec_t vt[15];

    initial begin
        int n, pulses, lat;
        logic [7:0] r;
        logic stable;

        vt[0]  = '{3'b000, 8'hA5, 8'h3C, 1'b1, 8'h24, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{3'b001, 8'hA5, 8'h3C, 1'b1, 8'hBD, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{3'b010, 8'hA5, 8'h3C, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{3'b011, 8'hA5, 8'h3C, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{3'b100, 8'hA5, 8'h3C, 1'b1, 8'hE2, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{3'b101, 8'hA5, 8'h3C, 1'b1, 8'h68, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{3'b110, 8'hA5, 8'h3C, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{3'b111, 8'hA5, 8'h3C, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{3'b100, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vt[9]  = '{3'b101, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0};
        vt[10] = '{3'b101, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
        vt[11] = '{3'b100, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
        vt[12] = '{3'b100, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        vt[13] = '{3'b101, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vt[14] = '{3'b000, 8'h0F, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};

        #1;
        chk("reset outputs", {21'd0, busy, done, result, cout, zero, ovf}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].ci,
                   vt[i].res, vt[i].co, vt[i].z, vt[i].v);
        end

        // start pulsed mid-RUN is ignored
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; code_op = 3'b100; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        pulses = 0; lat = 0; r = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                a = 8'hFF; b = 8'hFF; code_op = 3'b000; start = 1'b1;
            end
            if (i == 4) start = 1'b0;
            if (done) begin
                pulses++; lat = i; r = result;
            end
        end
        chk("ignore pulses", pulses, 32'd1);
        chk("ignore latency", lat, 32'd8);
        chk("ignore result", 32'(r), 32'h33);

        // start held through done: back-to-back
        @(negedge clk);
        a = 8'hF0; b = 8'h0F; cin = 1'b0; code_op = 3'b010; start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'h05; b = 8'h07; code_op = 3'b101;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk("b2b first latency", n, 32'd8);
        chk("b2b first result", {23'd0, result, cout}, {23'd0, 8'hFF, 1'b0});
        @(posedge clk);
        #1;
        chk("b2b accepted", {30'd0, busy, done}, 32'b10);
        start = 1'b0;
        n = 1; stable = 1'b1;
        while (!done && n < 20) begin
            if (result !== 8'hFF) stable = 1'b0;
            @(posedge clk);
            #1 n++;
        end
        chk("b2b first stable", 32'(stable), 32'd1);
        chk("b2b second spacing", n, 32'd9);
        chk("b2b second result", {22'd0, result, cout, zero}, {22'd0, 8'hFE, 1'b1, 1'b0});

        // reset mid-RUN
        @(negedge clk);
        a = 8'h40; b = 8'h02; cin = 1'b0; code_op = 3'b100; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun reset outputs", {21'd0, busy, done, result, cout, zero, ovf}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        chk("post reset quiet", pulses, 32'd0);
        run_op("post reset add", 3'b100, 8'h40, 8'h02, 1'b1, 8'h43, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_alu.md
# serial_alu

Bit-serial, parametrised successor to the single-bit ALU slice: processes two WIDTH-bit operands LSB-first, one bit per clock, through the same 3-bit opcode set with a registered carry/borrow chain. It sits between operand registers and a result consumer, trading throughput for a single 1-bit datapath. Operations use a start/busy/done handshake, and results are held stable until the next operation completes.

## Interface

- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only while idle.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in/borrow-in for arithmetic ops; captured on accepted start.
- code_op  input  3  opcode; captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when result, cout, zero and ovf update.
- result  output  WIDTH  result of the last completed operation.
- cout  output  1  carry-out (ADD) or borrow-out (SUB); 0 for logic ops.
- zero  output  1  high when the last completed result == 0.
- ovf  output  1  signed overflow of the last completed op (see Configuration).

## Operation

- Opcodes:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NOR
  - 100 ADD: {cout,result} = a + b + cin.
  - 101 SUB: result = a − b − cin mod 2^WIDTH; cout = 1 iff a < b + cin (unsigned).
  - 110 XNOR
  - 111 PASS A
- FSM states:
  - IDLE: busy=0. start=1 captures a, b, cin and code_op into shift registers, loads the carry flop with cin (0 for logic ops), clears the bit counter, and moves to RUN.
  - RUN: busy=1. Each edge computes bit i from the LSBs of the operand shift registers and the carry flop, shifts the bit into the internal result shift register from the MSB end, updates the carry flop, and increments the counter. After bit WIDTH−1 it returns to IDLE.
- On the final RUN edge:
  - result, cout, zero and ovf load together.
  - done=1 for exactly that one following cycle.
- Output registers are not touched at any other time, so partial results are never visible.
- start while busy=1 is ignored and not queued.
- start during the done cycle is accepted, because the FSM is already in IDLE. This gives back-to-back operation.
- Counter width is clog2(WIDTH); it counts 0..WIDTH−1 with no wrap beyond.

## Timing

- start sampled high at edge T0:
  - busy=1 from T0 through T0+WIDTH−1.
  - Bits 0..WIDTH−1 are processed at edges T0+1..T0+WIDTH.
  - At edge T0+WIDTH: busy falls, done rises, and the outputs update.
- Latency is WIDTH cycles from the accepting edge to done. Peak throughput is one op per WIDTH+1 cycles when start is asserted during done.
- Reset values (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, result=0, cout=0, zero=0, ovf=0, counter=0.
- Reset mid-RUN aborts the operation immediately. No done is issued, and the outputs go to their reset values.
- Deassertion of rst_n must be synchronous to clk externally. The first start is accepted at the first edge after deassertion.

## Configuration

- SERIAL_ALU_OVF_EN defined:
  - ovf = carry into the MSB XOR carry out of the MSB, for ADD and SUB (SUB uses the internal two's-complement carry).
  - ovf = 0 for all logic ops.
- SERIAL_ALU_OVF_EN undefined:
  - The ovf port is still present but tied to 0.
  - No overflow logic is synthesised.

## Test plan

All scenarios use WIDTH=8.

- ADD a=0xFF, b=0x01, cin=0 -> done exactly 8 cycles after the start edge; result=0x00, cout=1, zero=1, ovf=0.
- SUB a=0x10, b=0x20, cin=0 -> result=0xF0, cout=1, zero=0. SUB a=0x80, b=0x01, cin=0 -> result=0x7F, ovf=1 with the macro defined and 0 without it.
- Sweep all 8 opcodes with a=0xA5, b=0x3C, cin=1:
  - AND=0x24, OR=0xBD, XOR=0x99, NOR=0x42, ADD=0xE2, SUB=0x68, XNOR=0x66, PASS=0xA5.
  - cout=0 for every logic op.
- start pulsed again 3 cycles into RUN with different operands -> ignored; the original result is delivered; exactly one done pulse.
- start held high through the done cycle -> the second op is accepted on the done edge; its done follows 8 cycles later; the first result is stable in between.
- rst_n pulled low 4 cycles into an ADD -> busy, done and all outputs go to 0 immediately; no done after release; the next start runs normally.
